// File: rtl/flit_serializer_pkg.sv
// Shared types for the flit serializer.
// Contents: state_e, the serializer FSM state encoding.
package flit_serializer_pkg;

  // IDLE : no word held, next accept is a header
  // HDR  : shifting out a header word
  // PWAIT: no word held, next accept is a payload word
  // PLD  : shifting out a payload word
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_PWAIT = 2'd2,
    ST_PLD   = 2'd3
  } state_e;

endpackage : flit_serializer_pkg

// File: rtl/flit_serializer.sv
// Flit serializer: accepts DATA_SIZE-bit words (header + N payload words) and
// emits them LSB-first as OUT_SIZE-bit slices with sop/eop packet framing.
// Ports:
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   rx_i, rx_ack_o, data_i upstream word handshake and data
//   tx_o, tx_ack_i, data_o downstream slice handshake and data
//   sop_o, eop_o           first slice of header / last slice of packet
module flit_serializer
  import flit_serializer_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned OUT_SIZE  = 8,
  parameter int unsigned LEN_SIZE  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic                 rx_ack_o,
  input  logic [DATA_SIZE-1:0] data_i,
  output logic                 tx_o,
  input  logic                 tx_ack_i,
  output logic [OUT_SIZE-1:0]  data_o,
  output logic                 sop_o,
  output logic                 eop_o
);

  localparam int unsigned NSLICE = DATA_SIZE / OUT_SIZE;
  localparam int unsigned SW     = $clog2(NSLICE);
  localparam logic [SW-1:0] LAST_SLICE = SW'(NSLICE - 1);

  state_e               state_q, state_d;
  logic [SW-1:0]        slice_q, slice_d;
  logic [LEN_SIZE-1:0]  rem_q, rem_d;
  logic [DATA_SIZE-1:0] hold_q, hold_d;
  logic                 tx_q, tx_d;
  logic                 sop_q, sop_d;
  logic                 eop_q, eop_d;

  logic busy, last, rx_ack, accept, tx_xfer;

  // Handshake decode; a new word may be taken on the last-slice transfer
  // (payload or next header) so packets stream without bubbles.
  always_comb begin
    busy    = (state_q == ST_HDR) || (state_q == ST_PLD);
    last    = (slice_q == LAST_SLICE);
    tx_xfer = tx_q && tx_ack_i;
    rx_ack  = !busy || (last && tx_ack_i);
    accept  = rx_i && rx_ack;
  end

  // Next-state, counters and holding register
  always_comb begin
    state_d = state_q;
    slice_d = slice_q;
    rem_d   = rem_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_HDR;
          hold_d  = data_i;
          rem_d   = data_i[LEN_SIZE-1:0];
          slice_d = '0;
        end
      end
      ST_PWAIT: begin
        if (accept) begin
          state_d = ST_PLD;
          hold_d  = data_i;
          rem_d   = rem_q - LEN_SIZE'(1);
          slice_d = '0;
        end
      end
      ST_HDR, ST_PLD: begin
        if (tx_xfer) begin
          if (last) begin
            slice_d = '0;
            if (accept) begin
              hold_d = data_i;
              // rem_q == 0 means the packet is complete: this word is a header
              if (rem_q == '0) begin
                state_d = ST_HDR;
                rem_d   = data_i[LEN_SIZE-1:0];
              end else begin
                state_d = ST_PLD;
                rem_d   = rem_q - LEN_SIZE'(1);
              end
            end else begin
              state_d = (rem_q == '0) ? ST_IDLE : ST_PWAIT;
            end
          end else begin
            slice_d = slice_q + SW'(1);
            hold_d  = hold_q >> OUT_SIZE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tx_d  = (state_d == ST_HDR) || (state_d == ST_PLD);
    sop_d = (state_d == ST_HDR) && (slice_d == '0);
    eop_d = tx_d && (slice_d == LAST_SLICE) && (rem_d == '0);
  end

  // FSM, counters and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      slice_q <= '0;
      rem_q   <= '0;
      tx_q    <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slice_q <= slice_d;
      rem_q   <= rem_d;
      tx_q    <= tx_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  // Data path holding register, left unreset
  always_ff @(posedge clk_i) begin
    hold_q <= hold_d;
  end

  assign rx_ack_o = rx_ack;
  assign tx_o     = tx_q;
  assign sop_o    = sop_q;
  assign eop_o    = eop_q;
  assign data_o   = hold_q[OUT_SIZE-1:0];

endmodule : flit_serializer

// File: tb/tb_flit_serializer.sv
// Self-checking bench for flit_serializer (DATA 32, OUT 8, LEN 4).
// Driver offers words and pushes expected slices into a scoreboard queue;
// a negedge monitor pops and compares on every output transfer.
module tb_flit_serializer;

  localparam int unsigned DW = 32;
  localparam int unsigned OW = 8;
  localparam int unsigned LW = 4;
  localparam int unsigned NS = DW / OW;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          rx_i = 1'b0;
  logic          rx_ack_o;
  logic [DW-1:0] data_i = '0;
  logic          tx_o;
  logic          tx_ack_i = 1'b0;
  logic [OW-1:0] data_o;
  logic          sop_o;
  logic          eop_o;

  flit_serializer #(.DATA_SIZE(DW), .OUT_SIZE(OW), .LEN_SIZE(LW)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .rx_i     (rx_i),
    .rx_ack_o (rx_ack_o),
    .data_i   (data_i),
    .tx_o     (tx_o),
    .tx_ack_i (tx_ack_i),
    .data_o   (data_o),
    .sop_o    (sop_o),
    .eop_o    (eop_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [OW-1:0] data;
    bit            sop;
    bit            eop;
    int            idx;
  } exp_t;

  typedef struct {
    logic [OW-1:0] data;
    bit            sop;
    bit            eop;
  } log_t;

  exp_t          exp_q[$];
  log_t          log_q[$];
  logic [DW-1:0] pend[$];

  int checks = 0;
  int errors = 0;
  int n_pop = 0;
  int n_stall = 0;
  int cur_run = 0;
  int max_run = 0;

  // Reference model state: packet-level bookkeeping only
  bit expect_hdr = 1'b1;
  int words_left = 0;

  bit            prev_stall = 1'b0;
  logic [OW-1:0] prev_data;
  logic          prev_sop, prev_eop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A word entering the block becomes NS expected slices, LSB first
  task automatic model_accept(input logic [DW-1:0] w);
    bit is_hdr;
    bit last_word;
    exp_t e;
    is_hdr = expect_hdr;
    if (expect_hdr) words_left = int'(w[LW-1:0]);
    else            words_left = words_left - 1;
    last_word  = (words_left == 0);
    expect_hdr = last_word;
    for (int i = 0; i < int'(NS); i++) begin
      e.data = w[i*OW +: OW];
      e.sop  = is_hdr && (i == 0);
      e.eop  = last_word && (i == int'(NS) - 1);
      e.idx  = i;
      exp_q.push_back(e);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk_i) begin
    exp_t e;
    log_t l;
    if (!rst_ni) begin
      prev_stall = 1'b0;
      cur_run    = 0;
    end else begin
      if (!tx_o) begin
        chk("rx_ack_when_empty", 32'(rx_ack_o), 32'd1);
      end else if (!tx_ack_i) begin
        chk("rx_ack_when_stalled", 32'(rx_ack_o), 32'd0);
        n_stall++;
      end else if (exp_q.size() == 0) begin
        chk("unexpected_slice", 32'(tx_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("slice_data", 32'(data_o), 32'(e.data));
        chk("slice_sop", 32'(sop_o), 32'(e.sop));
        chk("slice_eop", 32'(eop_o), 32'(e.eop));
        chk("rx_ack_on_xfer", 32'(rx_ack_o), 32'(e.idx == int'(NS) - 1));
        l.data = data_o; l.sop = sop_o; l.eop = eop_o;
        log_q.push_back(l);
        n_pop++;
      end
      if (prev_stall && tx_o) begin
        chk("stall_data_stable", 32'(data_o), 32'(prev_data));
        chk("stall_sop_stable", 32'(sop_o), 32'(prev_sop));
        chk("stall_eop_stable", 32'(eop_o), 32'(prev_eop));
      end
      prev_stall = tx_o && !tx_ack_i;
      prev_data  = data_o;
      prev_sop   = sop_o;
      prev_eop   = eop_o;
      if (tx_o) cur_run++;
      else      cur_run = 0;
      if (cur_run > max_run) max_run = cur_run;
    end
  end

  // One clock of stimulus; reports whether the offered word was taken
  task automatic cycle(input bit rxv, input logic [DW-1:0] d, input bit ack, output bit acc);
    @(posedge clk_i);
    #1;
    rx_i     = rxv;
    data_i   = d;
    tx_ack_i = ack;
    @(negedge clk_i);
    #1;
    acc = rxv && rx_ack_o;
    if (acc) model_accept(d);
  endtask

  // Feed pend[] and drain the scoreboard, optionally stopping at a pop count
  task automatic run_pending(input int rx_pct, input int ack_pct, input int max_cyc, input int stop_pop);
    int cyc;
    bit rxv, ack, acc;
    logic [DW-1:0] d;
    cyc = 0;
    while ((pend.size() > 0 || exp_q.size() > 0) && cyc < max_cyc &&
           !(stop_pop >= 0 && n_pop >= stop_pop)) begin
      rxv = (pend.size() > 0) && ($urandom_range(1, 100) <= rx_pct);
      d   = rxv ? pend[0] : DW'($urandom);
      ack = ($urandom_range(1, 100) <= ack_pct);
      cycle(rxv, d, ack, acc);
      if (acc) void'(pend.pop_front());
      cyc++;
    end
    chk("run_within_budget", 32'(cyc >= max_cyc), 32'd0);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, acc);
  endtask

  logic [OW-1:0] e35 [12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB,
                              8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
  logic [OW-1:0] e36 [8]  = '{8'h00, 8'h00, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    int base;
    bit acc;
    logic [DW-1:0] w;
    logic [DW-1:0] hdr;

    // Reset state
    #1;
    chk("reset_tx", 32'(tx_o), 32'd0);
    chk("reset_sop", 32'(sop_o), 32'd0);
    chk("reset_eop", 32'(eop_o), 32'd0);
    chk("reset_rx_ack", 32'(rx_ack_o), 32'd1);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    idle(2);

    // Header N=2 with two payload words, downstream always ready
    log_q.delete();
    pend = '{32'h0000_0002, 32'hDDCC_BBAA, 32'h4433_2211};
    run_pending(100, 100, 200, -1);
    chk("r035_count", 32'(log_q.size()), 32'd12);
    for (int i = 0; i < 12 && i < log_q.size(); i++) begin
      chk($sformatf("r035_data%0d", i), 32'(log_q[i].data), 32'(e35[i]));
      chk($sformatf("r035_sop%0d", i), 32'(log_q[i].sop), 32'(i == 0));
      chk($sformatf("r035_eop%0d", i), 32'(log_q[i].eop), 32'(i == 11));
    end
    idle(2);

    // Header with N=0, then a second header with N=0
    log_q.delete();
    pend = '{32'h1234_0000, 32'h0000_0000};
    run_pending(100, 100, 200, -1);
    chk("r036_count", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      chk($sformatf("r036_data%0d", i), 32'(log_q[i].data), 32'(e36[i]));
      chk($sformatf("r036_sop%0d", i), 32'(log_q[i].sop), 32'(i % 4 == 0));
      chk($sformatf("r036_eop%0d", i), 32'(log_q[i].eop), 32'(i % 4 == 3));
    end
    idle(2);

    // Two back-to-back N=1 packets stream with no bubble
    max_run = 0;
    pend = '{32'hA5A5_0001, DW'($urandom), 32'h5A5A_0001, DW'($urandom)};
    run_pending(100, 100, 200, -1);
    chk("r037_no_bubble_run", 32'(max_run), 32'd16);
    idle(2);

    // Five-cycle stall on slice 3 with a word offered throughout
    log_q.delete();
    hdr  = 32'h00C3_B201;
    pend = '{hdr, 32'h8765_4321};
    base = n_pop;
    run_pending(100, 100, 200, base + 2);
    base = n_stall;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, pend[0], 1'b0, acc);
      chk("r038_no_accept_in_stall", 32'(acc), 32'd0);
      if (acc) void'(pend.pop_front());
    end
    chk("r038_stall_cycles", 32'(n_stall - base), 32'd5);
    run_pending(100, 100, 200, -1);
    chk("r038_count", 32'(log_q.size()), 32'd8);
    if (log_q.size() >= 3) chk("r038_slice3", 32'(log_q[2].data), 32'h0000_00C3);
    idle(2);

    // Reset after six slices of the N=2 packet, then a fresh N=0 header
    pend = '{32'h0000_0002, 32'hDDCC_BBAA, 32'h4433_2211};
    base = n_pop;
    run_pending(100, 100, 200, base + 6);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    rx_i   = 1'b0;
    exp_q.delete();
    pend.delete();
    expect_hdr = 1'b1;
    words_left = 0;
    #1;
    chk("r039_tx_after_reset", 32'(tx_o), 32'd0);
    chk("r039_sop_after_reset", 32'(sop_o), 32'd0);
    chk("r039_eop_after_reset", 32'(eop_o), 32'd0);
    chk("r039_rx_ack_after_reset", 32'(rx_ack_o), 32'd1);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    log_q.delete();
    pend = '{32'h0000_0000};
    run_pending(100, 100, 200, -1);
    chk("r039_count", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk($sformatf("r039_sop%0d", i), 32'(log_q[i].sop), 32'(i == 0));
      chk($sformatf("r039_eop%0d", i), 32'(log_q[i].eop), 32'(i == 3));
    end
    idle(2);

    // Maximum length N=15 gives 64 slices, eop only on the last
    log_q.delete();
    pend.push_back(32'hF00D_000F);
    for (int i = 0; i < 15; i++) pend.push_back(DW'($urandom));
    run_pending(100, 100, 400, -1);
    chk("r040_count", 32'(log_q.size()), 32'd64);
    begin
      int eops;
      eops = 0;
      foreach (log_q[i]) if (log_q[i].eop) eops++;
      chk("r040_eop_count", 32'(eops), 32'd1);
      if (log_q.size() == 64) chk("r040_eop_last", 32'(log_q[63].eop), 32'd1);
    end
    idle(2);

    // Randomized packets with random upstream gaps and downstream stalls
    for (int p = 0; p < 40; p++) begin
      hdr = DW'($urandom);
      hdr[LW-1:0] = LW'($urandom_range(0, 15));
      pend.push_back(hdr);
      for (int i = 0; i < int'(hdr[LW-1:0]); i++) begin
        w = DW'($urandom);
        pend.push_back(w);
      end
    end
    run_pending(70, 65, 20000, -1);
    idle(3);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("stimulus_drained", 32'(pend.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_flit_serializer
